inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch (IF) stage of the five-stage pipeline; the initiating/reading side of the combinational instruction ROM. Owns the program counter, drives the ROM word address every cycle, and registers the returned instruction into the IF/ID pipeline register. Obeys stall requests from the data-hazard unit and redirects from branch resolution. Keeps a sticky out-of-range flag and a retired-fetch counter for debug.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- ROM_AW, 6: ROM word-address width; ROM covers byte addresses 0 .. 4*2^ROM_AW-1.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  squash IF/ID (insert bubble) at this edge.
- branch_taken  in  1  redirect PC to branch_target at this edge.
- branch_target  in  32  byte address of redirect; bits [1:0] ignored (forced 0).
- rom_addr  out  32  byte address to ROM; equals PC register; ROM indexes bits [ROM_AW+1:2].
- rom_inst  in  32  instruction word from ROM, combinational from rom_addr.
- id_inst  out  32  registered instruction to ID.
- id_pc4  out  32  registered PC+4 of id_inst.
- id_valid  out  1  id_inst is a real instruction (0 = bubble).
- addr_oor  out  1  sticky: a fetch occurred with PC >= 4*2^ROM_AW.
- fetch_count  out  32  number of instructions accepted into IF/ID.

## Operation
- PC next-value priority per edge: rst > branch_taken > stall > PC+4.
  - rst: PC = RESET_PC.
  - branch_taken: PC = {branch_target[31:2], 2'b00}, regardless of stall.
  - stall (no branch): PC holds.
  - else PC = PC + 4, 32-bit modulo (0xFFFF_FFFC -> 0x0000_0000).
- IF/ID update priority per edge: rst > flush > branch_taken > stall > load.
  - rst, flush or branch_taken: id_inst = 0, id_pc4 = 0, id_valid = 0 (bubble; 0x00000000 is NOP).
  - stall: id_inst, id_pc4, id_valid hold.
  - load: id_inst = rom_inst, id_pc4 = PC + 4, id_valid = 1; fetch_count increments (wraps at 2^32).
- addr_oor: set on any load edge where PC[31:ROM_AW+2] != 0; cleared only by rst. Fetch still proceeds (ROM aliases on low bits).
- Two-state control FSM: RESET (entered on rst; outputs at reset values) -> RUN on first non-reset edge; RUN stays until rst. No other states.

## Timing
- Reset values: rom_addr = RESET_PC, id_inst = 0, id_pc4 = 0, id_valid = 0, addr_oor = 0, fetch_count = 0.
- First edge after rst deasserts: IF/ID loads ROM word at RESET_PC, id_valid = 1.
- Fetch latency: word at PC visible on id_inst exactly one edge after PC is presented on rom_addr.
- Redirect penalty: one bubble; target instruction reaches id_inst on the second edge after branch_taken.
- Stall held N cycles: PC and IF/ID frozen N edges, no fetch_count change; resume on next edge.
- stall and flush together: PC holds, IF/ID becomes bubble.
- rst mid-stall or mid-branch: rst wins; all state returns to reset values at that edge.
- No combinational path from stall/flush/branch inputs to any output.

## Structure
- Shared pipeline package holds: NOP word (32'h0), instruction width (32), PC increment (4), RESET_PC default.
- One sub-module natural: pc_reg (PC register with next-PC priority mux); IF/ID register, flag and counter stay in inst_fetch.

## Test plan
- Reset, ROM words 0x14000401/0x14000802/0x14001003 at 0/4/8, run 3 cycles -> id_inst sequence 0x14000401, 0x14000802, 0x14001003; id_pc4 4, 8, 12; fetch_count 3.
- Stall held 2 cycles while id_inst = 0x14000802 -> rom_addr stays 8, id_inst holds 0x14000802 for 2 extra cycles, fetch_count unchanged; then 0x14001003.
- branch_taken with target 0x0000_0015 at PC 8 -> rom_addr becomes 0x14, one bubble (id_valid 0, id_inst 0), then ROM[5] with id_pc4 0x18.
- branch_taken and stall same edge -> PC takes target, IF/ID bubble; flush and stall same edge -> PC held, IF/ID bubble.
- Branch to 0x100 with ROM_AW = 6 -> addr_oor = 1 after load edge, id_inst = ROM[0]; remains 1 until rst.
- Assert rst during a 3-cycle stall -> next edge all outputs at reset values, rom_addr = RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared pipeline constants and types for the instruction-fetch stage.
// Holds the NOP word, instruction width, PC increment and default reset PC.
package inst_fetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RESET,
    ST_RUN
  } fetch_state_t;

  // Branch targets are word addresses; the byte-offset bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: pipeline control in, ROM request/response, IF/ID register out.
// The master side is the fetch stage itself.
interface inst_fetch_if;

  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        addr_oor;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, rom_inst,
    output rom_addr, id_inst, id_pc4, id_valid, addr_oor, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, rom_inst,
    input  rom_addr, id_inst, id_pc4, id_valid, addr_oor, fetch_count
  );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with next-PC priority: reset, redirect, stall hold, then PC+4.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // A redirect overrides a stall so the hazard unit cannot lose a taken branch.
  always_comb begin
    pc_next = pc + PC_INC;
    if (branch_taken) begin
      pc_next = word_align(branch_target);
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the ROM from the PC, registers IF/ID,
// and keeps a sticky out-of-range flag plus a retired-fetch counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned ROM_AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  logic [31:0]       pc;
  logic [INST_W-1:0] id_inst_q;
  logic [31:0]       id_pc4_q;
  logic              id_valid_q;
  logic              addr_oor_q;
  logic [31:0]       fetch_count_q;
  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              fetch_en;
  logic              load;
  logic              pc_oor;

  inst_fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (bus.stall),
    .branch_taken (bus.branch_taken),
    .branch_target(bus.branch_target),
    .pc           (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // The first edge out of reset already fetches RESET_PC, so both states fetch.
  always_comb begin
    fetch_en = 1'b0;
    case (state_q)
      ST_RESET: fetch_en = 1'b1;
      ST_RUN:   fetch_en = 1'b1;
      default:  fetch_en = 1'b0;
    endcase
  end

  assign load   = fetch_en && !bus.stall;
  assign pc_oor = (pc >> (ROM_AW + 2)) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst_q     <= NOP_WORD;
      id_pc4_q      <= '0;
      id_valid_q    <= 1'b0;
      addr_oor_q    <= 1'b0;
      fetch_count_q <= '0;
    end else if (bus.flush || bus.branch_taken) begin
      id_inst_q  <= NOP_WORD;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else if (load) begin
      id_inst_q     <= bus.rom_inst;
      id_pc4_q      <= pc + PC_INC;
      id_valid_q    <= 1'b1;
      fetch_count_q <= fetch_count_q + 32'd1;
      if (pc_oor) begin
        addr_oor_q <= 1'b1;
      end
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_pc4      = id_pc4_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.addr_oor    = addr_oor_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// control traffic compared against a behavioural model of the fetch stage.
module tb_inst_fetch;

  localparam int unsigned ROM_WORDS = 64;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] rom [ROM_WORDS];
  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid, m_oor;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .ROM_AW  (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_inst = rom[bus.rom_addr[7:2]];

  // Advance one edge; the model applies the fetch-stage rules to the inputs
  // present before the edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] word;
    logic [31:0] cur;
    word = rom[m_pc[7:2]];
    cur  = m_pc;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_oor = 1'b0; m_cnt = 32'h0;
    end else begin
      if (bus.branch_taken)  m_pc = {bus.branch_target[31:2], 2'b00};
      else if (!bus.stall)   m_pc = cur + 32'd4;
      if (bus.flush || bus.branch_taken) begin
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_inst = word; m_pc4 = cur + 32'd4; m_valid = 1'b1;
        m_cnt  = m_cnt + 32'd1;
        if (cur >= 32'd256) m_oor = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want %h", bus.rom_addr, 32'h0); end
    checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h want %h", bus.id_inst, 32'h0); end
    checks++; if (bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_id_pc4: got %h want %h", bus.id_pc4, 32'h0); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.addr_oor !== 1'b0) begin errors++; $display("FAIL reset_addr_oor: got %b want 0", bus.addr_oor); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fetch_count: got %0d want 0", bus.fetch_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'h1400_0401; exp_inst[1] = 32'h1400_0802; exp_inst[2] = 32'h1400_1003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.id_inst !== exp_inst[i]) begin errors++; $display("FAIL seq_inst%0d: got %h want %h", i, bus.id_inst, exp_inst[i]); end
      checks++; if (bus.id_pc4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc4%0d: got %h want %h", i, bus.id_pc4, 32'(4 * (i + 1))); end
      checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, bus.id_valid); end
    end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.rom_addr !== 32'h8) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, bus.rom_addr, 32'h8); end
      checks++; if (bus.id_inst !== 32'h1400_0802) begin errors++; $display("FAIL stall_inst%0d: got %h want %h", i, bus.id_inst, 32'h1400_0802); end
      checks++; if (bus.fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count%0d: got %0d want 2", i, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.id_inst !== 32'h1400_1003) begin errors++; $display("FAIL stall_resume: got %h want %h", bus.id_inst, 32'h1400_1003); end
    checks++; if (bus.id_pc4 !== 32'd12) begin errors++; $display("FAIL stall_resume_pc4: got %h want %h", bus.id_pc4, 32'd12); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0015;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.rom_addr !== 32'h14) begin errors++; $display("FAIL br_pc: got %h want %h", bus.rom_addr, 32'h14); end
    checks++; if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0) begin errors++; $display("FAIL br_bubble: got v=%b i=%h want v=0 i=0", bus.id_valid, bus.id_inst); end
    tick();
    checks++; if (bus.id_inst !== rom[5]) begin errors++; $display("FAIL br_target_inst: got %h want %h", bus.id_inst, rom[5]); end
    checks++; if (bus.id_pc4 !== 32'h18) begin errors++; $display("FAIL br_target_pc4: got %h want %h", bus.id_pc4, 32'h18); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    tick(); tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0020; bus.stall = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.rom_addr !== 32'h20) begin errors++; $display("FAIL brst_pc: got %h want %h", bus.rom_addr, 32'h20); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL brst_bubble: got %b want 0", bus.id_valid); end
    tick();
    bus.flush = 1'b1; bus.stall = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.rom_addr !== 32'h24) begin errors++; $display("FAIL flst_pc: got %h want %h", bus.rom_addr, 32'h24); end
    checks++; if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL flst_bubble: got v=%b i=%h p=%h want 0/0/0", bus.id_valid, bus.id_inst, bus.id_pc4); end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL flst_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_oor();
    do_reset();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0100;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.addr_oor !== 1'b0) begin errors++; $display("FAIL oor_early: got %b want 0", bus.addr_oor); end
    tick();
    checks++; if (bus.addr_oor !== 1'b1) begin errors++; $display("FAIL oor_set: got %b want 1", bus.addr_oor); end
    checks++; if (bus.id_inst !== rom[0]) begin errors++; $display("FAIL oor_alias: got %h want %h", bus.id_inst, rom[0]); end
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0004;
    tick();
    bus.branch_taken = 1'b0;
    tick(); tick();
    checks++; if (bus.addr_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", bus.addr_oor); end
    do_reset();
    checks++; if (bus.addr_oor !== 1'b0) begin errors++; $display("FAIL oor_clear: got %b want 0", bus.addr_oor); end
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    tick();
    rst = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    tick();
    idle_inputs();
    checks++; if (bus.rom_addr !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_pc4 !== 32'h0 || bus.id_valid !== 1'b0 || bus.fetch_count !== 32'h0 || bus.addr_oor !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall: got pc=%h i=%h p=%h v=%b c=%0d o=%b want all zero",
               bus.rom_addr, bus.id_inst, bus.id_pc4, bus.id_valid, bus.fetch_count, bus.addr_oor);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) < 3);
      bus.stall        = ($urandom_range(0, 99) < 25);
      bus.flush        = ($urandom_range(0, 99) < 10);
      bus.branch_taken = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 9))
        0:       bus.branch_target = $urandom;
        1:       bus.branch_target = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        default: bus.branch_target = 32'($urandom_range(0, 511));
      endcase
      if (n % 50 == 0) rom[$urandom_range(0, ROM_WORDS - 1)] = $urandom;
      tick();
      checks++;
      if (bus.rom_addr !== m_pc || bus.id_inst !== m_inst || bus.id_pc4 !== m_pc4 ||
          bus.id_valid !== m_valid || bus.addr_oor !== m_oor || bus.fetch_count !== m_cnt) begin
        errors++;
        if (bad < 10) $display("FAIL rand%0d: got pc=%h i=%h p=%h v=%b o=%b c=%0d want pc=%h i=%h p=%h v=%b o=%b c=%0d",
                               n, bus.rom_addr, bus.id_inst, bus.id_pc4, bus.id_valid, bus.addr_oor, bus.fetch_count,
                               m_pc, m_inst, m_pc4, m_valid, m_oor, m_cnt);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'h0A00_0000 | 32'(i);
    rom[0] = 32'h1400_0401;
    rom[1] = 32'h1400_0802;
    rom[2] = 32'h1400_1003;
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_oor = 1'b0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_oor();
    test_rst_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
